// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner: the hex glyph table (ABCDEFG,
// bit6 = A .. bit0 = G, active-high) and a decode helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_HEX_0 = 7'b1111110;
  localparam logic [6:0] SEG_HEX_1 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_2 = 7'b1101101;
  localparam logic [6:0] SEG_HEX_3 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_4 = 7'b0110011;
  localparam logic [6:0] SEG_HEX_5 = 7'b1011011;
  localparam logic [6:0] SEG_HEX_6 = 7'b1011111;
  localparam logic [6:0] SEG_HEX_7 = 7'b1110000;
  localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
  localparam logic [6:0] SEG_HEX_9 = 7'b1111011;
  localparam logic [6:0] SEG_HEX_A = 7'b1110111;
  localparam logic [6:0] SEG_HEX_B = 7'b0011111;
  localparam logic [6:0] SEG_HEX_C = 7'b1001110;
  localparam logic [6:0] SEG_HEX_D = 7'b0111101;
  localparam logic [6:0] SEG_HEX_E = 7'b1001111;
  localparam logic [6:0] SEG_HEX_F = 7'b1000111;

  // Nibble to active-high segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] pattern;
    pattern = SEG_BLANK;
    case (nibble)
      4'h0: pattern = SEG_HEX_0;
      4'h1: pattern = SEG_HEX_1;
      4'h2: pattern = SEG_HEX_2;
      4'h3: pattern = SEG_HEX_3;
      4'h4: pattern = SEG_HEX_4;
      4'h5: pattern = SEG_HEX_5;
      4'h6: pattern = SEG_HEX_6;
      4'h7: pattern = SEG_HEX_7;
      4'h8: pattern = SEG_HEX_8;
      4'h9: pattern = SEG_HEX_9;
      4'hA: pattern = SEG_HEX_A;
      4'hB: pattern = SEG_HEX_B;
      4'hC: pattern = SEG_HEX_C;
      4'hD: pattern = SEG_HEX_D;
      4'hE: pattern = SEG_HEX_E;
      4'hF: pattern = SEG_HEX_F;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle between a status-register source (master) and the display
// scanner (slave): display content/controls in, display pin drive out.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [3:0]              brightness;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output data_in, dp_in, digit_en, lz_blank, brightness,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  data_in, dp_in, digit_en, lz_blank, brightness,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex-nibble to 7-segment (active-high ABCDEFG) decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: per-digit time slots with an anti-ghost
// blank window, 16-level PWM, leading-zero blanking and a per-frame input
// snapshot so that a digit never shows a mix of old and new values.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 1024,
  parameter int BLANK_CYCLES   = 32,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic          clk,
  input logic          rst,
  seg7_scan_driver_if.slave bus
);

  localparam int CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP = (PRESCALE - BLANK_CYCLES) / 16;
  // One spare bit keeps STEP*16 representable even with no blank window.
  localparam int PW   = CW + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] BLANK_P  = PW'(BLANK_CYCLES);
  localparam logic [PW-1:0] STEP_P   = PW'(STEP);

  // Scan position
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dig_q, dig_d;

  // Frame snapshot of the inputs
  logic [4*NUM_DIGITS-1:0] data_q, data_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    lz_q, lz_d;
  logic [3:0]              bri_q, bri_d;

  // Registered pin drive (active-high internally)
  logic                  frame_start_q;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_out_q, dp_out_d;

  logic                  snap;
  logic [NUM_DIGITS:1]   zero_from;
  logic [NUM_DIGITS-1:0] blanked;
  logic [3:0]            nibble;
  logic [6:0]            pattern;
  logic [PW-1:0]         rel, limit;
  logic                  in_window;
  logic                  digit_on;

  assign snap = (cnt_q == '0) && (dig_q == '0);

  // Slot counter wraps at PRESCALE-1 and steps the digit index.
  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    dig_d = dig_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + DW'(1);
    end
  end

  // Capture all display inputs once per frame, at the start of digit 0.
  // The downstream logic uses the _d values so the capture cycle already
  // sees the new frame.
  always_comb begin
    data_d = data_q;
    dp_d   = dp_q;
    en_d   = en_q;
    lz_d   = lz_q;
    bri_d  = bri_q;
    if (snap) begin
      data_d = bus.data_in;
      dp_d   = bus.dp_in;
      en_d   = bus.digit_en;
      lz_d   = bus.lz_blank;
      bri_d  = bus.brightness;
    end
  end

  // Leading-zero blanking: digit k goes dark when it and every digit above
  // it are zero with no decimal point; digit 0 always shows.
  always_comb begin
    zero_from = '0;
    blanked   = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (k == NUM_DIGITS - 1) begin
        zero_from[k] = (data_d[4*k +: 4] == 4'h0) && !dp_d[k];
      end else begin
        zero_from[k] = zero_from[k+1] && (data_d[4*k +: 4] == 4'h0) && !dp_d[k];
      end
      blanked[k] = lz_d && zero_from[k];
    end
  end

  assign nibble = data_d[{dig_q, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (pattern)
  );

  // PWM window: on from BLANK_CYCLES for STEP*(brightness+1) cycles.
  always_comb begin
    rel       = PW'(cnt_q) - BLANK_P;
    limit     = STEP_P * (PW'(bri_d) + PW'(1));
    in_window = (PW'(cnt_q) >= BLANK_P) && (rel < limit);
    digit_on  = en_d[dig_q] && !blanked[dig_q] && in_window;
  end

  // Next pin drive: the selected digit when lit, otherwise everything dark.
  always_comb begin
    an_d     = '0;
    seg_d    = SEG_BLANK;
    dp_out_d = 1'b0;
    if (digit_on) begin
      an_d[dig_q] = 1'b1;
      seg_d       = pattern;
      dp_out_d    = dp_d[dig_q];
    end
  end

  // State and output registers; reset darkens the display immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      dig_q         <= '0;
      // NOTE: the shadow registers are reset even though the first clock overwrites them, so no X can reach the pins.
      data_q        <= '0;
      dp_q          <= '0;
      en_q          <= '0;
      lz_q          <= 1'b0;
      bri_q         <= '0;
      frame_start_q <= 1'b0;
      an_q          <= '0;
      seg_q         <= SEG_BLANK;
      dp_out_q      <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      dig_q         <= dig_d;
      data_q        <= data_d;
      dp_q          <= dp_d;
      en_q          <= en_d;
      lz_q          <= lz_d;
      bri_q         <= bri_d;
      frame_start_q <= snap;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_out_q      <= dp_out_d;
    end
  end

  // Pin polarity is applied after the registers.
  assign bus.an          = (AN_ACTIVE_LOW != 0)  ? ~an_q     : an_q;
  assign bus.seg         = (SEG_ACTIVE_LOW != 0) ? ~seg_q    : seg_q;
  assign bus.dp          = (SEG_ACTIVE_LOW != 0) ? ~dp_out_q : dp_out_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: a cycle model pushes the
// expected pin state on every clock edge and the sampled DUT pins are
// popped against it, plus per-feature checks on per-frame tallies.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int PRE   = 64;
  localparam int BL    = 16;
  localparam int STEP  = (PRE - BL) / 16;
  localparam int FRAME = ND * PRE;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic          fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS     (ND),
    .PRESCALE       (PRE),
    .BLANK_CYCLES   (BL),
    .SEG_ACTIVE_LOW (0),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  exp_t sb [$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int              m_cnt, m_dig, m_last_cnt;
  logic [4*ND-1:0] sh_data;
  logic [ND-1:0]   sh_dp, sh_en;
  logic            sh_lz;
  logic [3:0]      sh_bri;

  // Per-frame tallies of what the DUT actually lit
  int         on_cnt   [ND];
  int         first_on [ND];
  logic [6:0] seg_seen [ND];
  logic       dp_seen  [ND];
  int         idle_cnt;
  int         cyc;
  int         last_fs;

  task automatic model_reset();
    m_cnt   = 0;
    m_dig   = 0;
    sh_data = '0;
    sh_dp   = '0;
    sh_en   = '0;
    sh_lz   = 1'b0;
    sh_bri  = '0;
    last_fs = -1;
  endtask

  task automatic model_step(output exp_t e);
    logic [3:0]    nib;
    logic          blank;
    logic          on;
    int            rel;
    logic [ND-1:0] onehot;
    e.fs = (m_cnt == 0) && (m_dig == 0);
    if (e.fs) begin
      sh_data = bus.data_in;
      sh_dp   = bus.dp_in;
      sh_en   = bus.digit_en;
      sh_lz   = bus.lz_blank;
      sh_bri  = bus.brightness;
    end
    nib   = sh_data[m_dig*4 +: 4];
    blank = 1'b0;
    if (sh_lz && m_dig > 0) begin
      blank = 1'b1;
      for (int k = m_dig; k < ND; k++)
        if (sh_data[k*4 +: 4] != 4'h0 || sh_dp[k]) blank = 1'b0;
    end
    rel    = m_cnt - BL;
    on     = sh_en[m_dig] && !blank && (rel >= 0) && (rel < STEP * (int'(sh_bri) + 1));
    onehot = '0;
    onehot[m_dig] = 1'b1;
    e.an  = on ? ~onehot : '1;
    e.seg = on ? dec_tab[nib] : 7'b0;
    e.dp  = on && sh_dp[m_dig];
    m_last_cnt = m_cnt;
    m_cnt++;
    if (m_cnt == PRE) begin
      m_cnt = 0;
      m_dig = (m_dig + 1) % ND;
    end
  endtask

  task automatic clear_tally();
    for (int k = 0; k < ND; k++) begin
      on_cnt[k]   = 0;
      first_on[k] = -1;
      seg_seen[k] = 'x;
      dp_seen[k]  = 1'bx;
    end
    idle_cnt = 0;
  endtask

  // One clock: push the model's expectation, then pop it against the pins.
  task automatic tick();
    exp_t          e, got;
    logic [ND-1:0] act;
    @(posedge clk);
    model_step(e);
    sb.push_back(e);
    #1;
    e   = sb.pop_front();
    got = {bus.an, bus.seg, bus.dp, bus.frame_start};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL scoreboard t=%0t got an=%b seg=%b dp=%b fs=%b, expected an=%b seg=%b dp=%b fs=%b",
               $time, got.an, got.seg, got.dp, got.fs, e.an, e.seg, e.dp, e.fs);
    end
    act = ~bus.an;
    n_checks++;
    if ($countones(act) > 1) begin
      n_fail++;
      $display("FAIL onehot t=%0t an=%b, required at most one active", $time, bus.an);
    end
    cyc++;
    if (bus.frame_start === 1'b1) begin
      if (last_fs >= 0) begin
        n_checks++;
        if (cyc - last_fs != FRAME) begin
          n_fail++;
          $display("FAIL frame_period got %0d, expected %0d", cyc - last_fs, FRAME);
        end
      end
      last_fs = cyc;
    end
    if (act == '0) idle_cnt++;
    for (int k = 0; k < ND; k++) begin
      if (act[k]) begin
        on_cnt[k]++;
        seg_seen[k] = bus.seg;
        dp_seen[k]  = bus.dp;
        if (first_on[k] < 0) first_on[k] = m_last_cnt;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Advance until the next edge is a snapshot edge, then clear tallies.
  task automatic sync_frame();
    int guard = 0;
    while (!(m_cnt == 0 && m_dig == 0) && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    if (guard >= 2 * FRAME) begin
      n_checks++;
      n_fail++;
      $display("FAIL sync_frame no frame boundary within %0d cycles", 2 * FRAME);
    end
    clear_tally();
  endtask

  task automatic set_inputs(input logic [4*ND-1:0] d, input logic [ND-1:0] p,
                            input logic [ND-1:0] en, input logic lz, input logic [3:0] b);
    bus.data_in    = d;
    bus.dp_in      = p;
    bus.digit_en   = en;
    bus.lz_blank   = lz;
    bus.brightness = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.an !== 4'hF) begin n_fail++; $display("FAIL reset_an got %b, expected 1111", bus.an); end
    n_checks++;
    if (bus.seg !== 7'b0) begin n_fail++; $display("FAIL reset_seg got %b, expected 0000000", bus.seg); end
    n_checks++;
    if (bus.dp !== 1'b0) begin n_fail++; $display("FAIL reset_dp got %b, expected 0", bus.dp); end
    n_checks++;
    if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b, expected 0", bus.frame_start); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_full_brightness();
    logic [3:0] nibs [ND] = '{4'hF, 4'hA, 4'h2, 4'h1};
    set_inputs(16'h12AF, 4'b0000, 4'hF, 1'b0, 4'd15);
    sync_frame();
    run(FRAME);
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (on_cnt[k] != PRE - BL) begin
        n_fail++;
        $display("FAIL full_on_cycles digit %0d got %0d, expected %0d", k, on_cnt[k], PRE - BL);
      end
      n_checks++;
      if (first_on[k] != BL) begin
        n_fail++;
        $display("FAIL full_first_on digit %0d got cnt %0d, expected %0d", k, first_on[k], BL);
      end
      n_checks++;
      if (seg_seen[k] !== dec_tab[nibs[k]]) begin
        n_fail++;
        $display("FAIL full_seg digit %0d got %b, expected %b", k, seg_seen[k], dec_tab[nibs[k]]);
      end
    end
  endtask

  task automatic test_min_brightness();
    bus.brightness = 4'd0;
    sync_frame();
    run(FRAME);
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (on_cnt[k] != STEP) begin
        n_fail++;
        $display("FAIL min_on_cycles digit %0d got %0d, expected %0d", k, on_cnt[k], STEP);
      end
    end
    n_checks++;
    if (idle_cnt != FRAME - ND * STEP) begin
      n_fail++;
      $display("FAIL min_idle_cycles got %0d, expected %0d", idle_cnt, FRAME - ND * STEP);
    end
  endtask

  task automatic test_lz_blank();
    set_inputs(16'h0050, 4'b0000, 4'hF, 1'b1, 4'd15);
    sync_frame();
    run(FRAME);
    n_checks++;
    if (on_cnt[3] != 0) begin n_fail++; $display("FAIL lz_digit3 lit %0d cycles, expected 0", on_cnt[3]); end
    n_checks++;
    if (on_cnt[2] != 0) begin n_fail++; $display("FAIL lz_digit2 lit %0d cycles, expected 0", on_cnt[2]); end
    n_checks++;
    if (seg_seen[1] !== dec_tab[5]) begin n_fail++; $display("FAIL lz_digit1_seg got %b, expected %b", seg_seen[1], dec_tab[5]); end
    n_checks++;
    if (seg_seen[0] !== dec_tab[0]) begin n_fail++; $display("FAIL lz_digit0_seg got %b, expected %b", seg_seen[0], dec_tab[0]); end
    bus.dp_in = 4'b0100;
    sync_frame();
    run(FRAME);
    n_checks++;
    if (on_cnt[2] != PRE - BL) begin n_fail++; $display("FAIL lzdp_digit2 lit %0d cycles, expected %0d", on_cnt[2], PRE - BL); end
    n_checks++;
    if (seg_seen[2] !== dec_tab[0]) begin n_fail++; $display("FAIL lzdp_digit2_seg got %b, expected %b", seg_seen[2], dec_tab[0]); end
    n_checks++;
    if (dp_seen[2] !== 1'b1) begin n_fail++; $display("FAIL lzdp_digit2_dp got %b, expected 1", dp_seen[2]); end
    n_checks++;
    if (on_cnt[3] != 0) begin n_fail++; $display("FAIL lzdp_digit3 lit %0d cycles, expected 0", on_cnt[3]); end
  endtask

  task automatic test_snapshot();
    set_inputs(16'h1111, 4'b0000, 4'hF, 1'b0, 4'd15);
    sync_frame();
    run(PRE + 20);
    bus.data_in = 16'h2222;
    run(FRAME - PRE - 20);
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (seg_seen[k] !== dec_tab[1]) begin
        n_fail++;
        $display("FAIL snap_old digit %0d got %b, expected %b", k, seg_seen[k], dec_tab[1]);
      end
    end
    sync_frame();
    run(FRAME);
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (seg_seen[k] !== dec_tab[2]) begin
        n_fail++;
        $display("FAIL snap_new digit %0d got %b, expected %b", k, seg_seen[k], dec_tab[2]);
      end
    end
  endtask

  task automatic test_reset_midslot();
    int off;
    int guard;
    set_inputs(16'h12AF, 4'b0000, 4'hF, 1'b0, 4'd15);
    sync_frame();
    run(30);
    n_checks++;
    if (bus.an !== 4'b1110) begin n_fail++; $display("FAIL midslot_lit got an=%b, expected 1110", bus.an); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.an !== 4'hF) begin n_fail++; $display("FAIL async_rst_an got %b, expected 1111", bus.an); end
    n_checks++;
    if (bus.seg !== 7'b0) begin n_fail++; $display("FAIL async_rst_seg got %b, expected 0000000", bus.seg); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb.delete();
    tick();
    n_checks++;
    if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL post_rst_fs got %b, expected 1", bus.frame_start); end
    off   = (bus.an === 4'hF) ? 1 : 0;
    guard = 0;
    while (bus.an === 4'hF && guard < 4 * PRE) begin
      tick();
      if (bus.an === 4'hF) off++;
      guard++;
    end
    n_checks++;
    if (off != BL) begin n_fail++; $display("FAIL post_rst_dark_edges got %0d, expected %0d", off, BL); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        set_inputs(16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc     = 0;
    last_fs = -1;
    clear_tally();
    set_inputs('0, '0, '0, 1'b0, 4'd0);
    test_reset();
    test_full_brightness();
    test_min_brightness();
    test_lz_blank();
    test_snapshot();
    test_reset_midslot();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
